oled_spi_scheduler: RTL and testbench

Shares the single OLED SPI write port (SCLK, nCS, DnC, SDIN) between two requesters inside comp_core: the command/initialisation sequencer and the frame-data streamer. It arbitrates byte requests, serialises each granted byte MSB first at a divided SCLK rate, and drives DnC from the winning requester. Command has priority; a run-length guard stops the data stream from starving.

---
 rtl/oled_spi_scheduler.sv | 174 +++++++++++++++++
 tb/tb_oled_spi_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_scheduler.sv
// oled_spi_scheduler
// Shares one OLED SPI write port (SCLK, nCS, DnC, SDIN) between the command
// sequencer and the frame-data streamer. Each granted byte is shifted MSB
// first in SPI mode 0, with SCLK half-period = CLK_DIV clocks.
// Command wins by default. After MAX_CMD_RUN consecutive command grants made
// while data was waiting, the next grant goes to data.
// Optional feature: define OLED_SPI_BURST_EN to chain back-to-back bytes from
// the same requester without releasing nCS (the GAP phase is skipped).
//
// Handshake: a requester raises *_req_i with *_byte_i stable and holds both
// until it sees its one-cycle *_ack_o pulse. The byte is captured on the clock
// edge that raises the ack. The requester may change or drop req/byte only
// after the ack has been observed.
module oled_spi_scheduler #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned MAX_CMD_RUN = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_req_i,
    input  logic [7:0] cmd_byte_i,
    output logic       cmd_ack_o,
    input  logic       data_req_i,
    input  logic [7:0] data_byte_i,
    output logic       data_ack_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       ncs_o,
    output logic       dnc_o,
    output logic       sdin_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] MAX_RUN  = 8'(MAX_CMD_RUN);

    state_t     state_q;
    logic [7:0] div_q;      // cycle count inside the current half-period
    logic [3:0] phase_q;    // half-period index within the byte (0..15)
    logic [7:0] run_q;      // consecutive command grants while data waited
    logic [7:0] shift_q;
    logic       sclk_q;
    logic       ncs_q;
    logic       dnc_q;
    logic       sdin_q;
    logic       cmd_ack_q;
    logic       data_ack_q;
    logic       busy_q;

    logic       div_last;
    logic       any_req_d;
    logic       pick_data_d;
    logic [7:0] run_d;
    logic [7:0] grant_byte_d;
    logic       grant_d;

    assign div_last = (div_q == DIV_LAST);

    // Arbitration: pick the winner, its byte, the next run count, and whether
    // this edge is a grant edge.
    always_comb begin
        any_req_d    = cmd_req_i | data_req_i;
        pick_data_d  = data_req_i & (~cmd_req_i | (run_q == MAX_RUN));
        run_d        = '0;
        if (!pick_data_d && data_req_i) begin
            run_d = run_q + 8'd1;
        end
        grant_byte_d = pick_data_d ? data_byte_i : cmd_byte_i;
        grant_d      = 1'b0;
        case (state_q)
            S_IDLE:  grant_d = any_req_d;
`ifdef OLED_SPI_BURST_EN
            // Chain only when the same requester wins at the end of HOLD.
            S_HOLD:  grant_d = div_last & any_req_d & (pick_data_d == dnc_q);
`endif
            default: grant_d = 1'b0;
        endcase
    end

    // Main FSM: grant/capture, bit serialisation, HOLD and GAP timing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            phase_q    <= '0;
            run_q      <= '0;
            shift_q    <= '0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            dnc_q      <= 1'b0;
            sdin_q     <= 1'b0;
            cmd_ack_q  <= 1'b0;
            data_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_ack_q  <= 1'b0;
            data_ack_q <= 1'b0;
            if (grant_d) begin
                state_q    <= S_SHIFT;
                div_q      <= '0;
                phase_q    <= '0;
                run_q      <= run_d;
                shift_q    <= grant_byte_d;
                sdin_q     <= grant_byte_d[7];
                sclk_q     <= 1'b0;
                ncs_q      <= 1'b0;
                dnc_q      <= pick_data_d;
                busy_q     <= 1'b1;
                cmd_ack_q  <= ~pick_data_d;
                data_ack_q <= pick_data_d;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_SHIFT: begin
                        if (div_last) begin
                            div_q <= '0;
                            if (phase_q == 4'd15) begin
                                state_q <= S_HOLD;
                                sclk_q  <= 1'b0;
                            end else begin
                                phase_q <= phase_q + 4'd1;
                                sclk_q  <= ~sclk_q;
                                // Falling SCLK edge: present the next bit.
                                if (sclk_q) begin
                                    sdin_q  <= shift_q[6];
                                    shift_q <= {shift_q[6:0], 1'b0};
                                end
                            end
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    S_HOLD: begin
                        if (div_last) begin
                            div_q   <= '0;
                            state_q <= S_GAP;
                            ncs_q   <= 1'b1;
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (div_last) begin
                            div_q   <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_ack_o  = cmd_ack_q;
    assign data_ack_o = data_ack_q;
    assign busy_o     = busy_q;
    assign sclk_o     = sclk_q;
    assign ncs_o      = ncs_q;
    assign dnc_o      = dnc_q;
    assign sdin_o     = sdin_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_oled_spi_scheduler.sv
// Bench for oled_spi_scheduler: random traffic checked against a reference
// model of the arbitration rules, plus an SPI monitor that rebuilds bytes.
module tb_oled_spi_scheduler;
  localparam int D    = 4;
  localparam int MAXR = 2;
`ifdef OLED_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_req = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       data_req = 1'b0;
  logic [7:0] data_byte = 8'h00;
  logic       cmd_ack, data_ack, busy, sclk, ncs, dnc, sdin;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];

  oled_spi_scheduler #(.CLK_DIV(D), .MAX_CMD_RUN(MAXR)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_req_i(cmd_req), .cmd_byte_i(cmd_byte), .cmd_ack_o(cmd_ack),
    .data_req_i(data_req), .data_byte_i(data_byte), .data_ack_o(data_ack),
    .busy_o(busy), .sclk_o(sclk), .ncs_o(ncs), .dnc_o(dnc), .sdin_o(sdin),
    .state_o(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI monitor: rebuild bytes from SCLK rises and score them against exp_q
  logic [7:0] mon_sh = 8'h00;
  int         mon_cnt = 0;
  logic       sclk_p = 1'b0;
  logic       sdin_p = 1'b0;
  logic       ack_p = 1'b0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst === 1'b1 || ncs === 1'b1) begin
      mon_cnt = 0;
    end else begin
      if (sclk === 1'b1 && sclk_p === 1'b1) begin
        n_cmp++;
        if (sdin !== sdin_p) begin
          n_fail++;
          $display("FAIL sdin_stable_high t=%0d got=%b want=%b", cyc, sdin, sdin_p);
        end
      end
      if (sclk === 1'b1 && sclk_p === 1'b0) begin
        mon_sh = {mon_sh[6:0], sdin};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte got=%b_%h want=none", dnc, mon_sh);
          end else begin
            e = exp_q.pop_front();
            if ({dnc, mon_sh} !== e) begin
              n_fail++;
              $display("FAIL spi_byte got dnc/byte=%b_%h want=%b_%h", dnc, mon_sh, e[8], e[7:0]);
            end
          end
        end
      end
    end
    if (rst !== 1'b1 && (cmd_ack === 1'b1 || data_ack === 1'b1)) begin
      n_cmp++;
      if (ack_p === 1'b1 || (cmd_ack === 1'b1 && data_ack === 1'b1)) begin
        n_fail++;
        $display("FAIL ack_pulse t=%0d got cmd/data=%b%b prev=%b want single one-cycle pulse",
                 cyc, cmd_ack, data_ack, ack_p);
      end
    end
    ack_p  = cmd_ack | data_ack;
    sclk_p = sclk;
    sdin_p = sdin;
  end

  // driver helpers
  task automatic wait_grant(output bit got, output bit is_data, output int t, output int ncs_hi);
    got = 1'b0; is_data = 1'b0; t = 0; ncs_hi = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1 || data_ack === 1'b1) begin
        got = 1'b1;
        is_data = (data_ack === 1'b1);
        t = cyc;
      end else if (ncs === 1'b1) begin
        ncs_hi++;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && ncs === 1'b1 && sclk === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_req = 1'b0; data_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ncs, sclk, sdin, dnc, cmd_ack, data_ack, busy} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_outputs got ncs,sclk,sdin,dnc,cack,dack,busy=%b want=1000000",
               {ncs, sclk, sdin, dnc, cmd_ack, data_ack, busy});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({ncs, sclk, busy, cmd_ack, data_ack} !== 5'b10000) begin
      n_fail++;
      $display("FAIL idle_no_req got ncs,sclk,busy,cack,dack=%b want=10000",
               {ncs, sclk, busy, cmd_ack, data_ack});
    end
  endtask

  task automatic test_single_cmd(input logic [7:0] b);
    bit got, isd;
    int t, nh, busy_n, ncs_n, ack_n, rise_n, first_rise, last_rise, dnc_bad;
    logic sp;
    cmd_byte = b; cmd_req = 1'b1;
    exp_q.push_back({1'b0, b});
    wait_grant(got, isd, t, nh);
    n_cmp++;
    if (!got || isd) begin
      n_fail++;
      $display("FAIL single_grant got got/is_data=%b%b want=10", got, isd);
    end
    cmd_req = 1'b0;
    busy_n = 0; ncs_n = 0; ack_n = 0; rise_n = 0; first_rise = -1; last_rise = -1; dnc_bad = 0;
    sp = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (ncs === 1'b0) begin
        ncs_n++;
        if (dnc !== 1'b0) dnc_bad++;
      end
      if (cmd_ack === 1'b1) ack_n++;
      if (sclk === 1'b1 && sp === 1'b0) begin
        rise_n++;
        if (first_rise < 0) first_rise = i;
        last_rise = i;
      end
      sp = sclk;
    end
    n_cmp++;
    if (busy_n != 18 * D) begin n_fail++; $display("FAIL busy_len got=%0d want=%0d", busy_n, 18 * D); end
    n_cmp++;
    if (ncs_n != 17 * D) begin n_fail++; $display("FAIL ncs_low_len got=%0d want=%0d", ncs_n, 17 * D); end
    n_cmp++;
    if (ack_n != 1) begin n_fail++; $display("FAIL cmd_ack_len got=%0d want=1", ack_n); end
    n_cmp++;
    if (rise_n != 8) begin n_fail++; $display("FAIL sclk_rises got=%0d want=8", rise_n); end
    n_cmp++;
    if (first_rise != D || last_rise != 15 * D) begin
      n_fail++;
      $display("FAIL sclk_rise_times got first=%0d last=%0d want first=%0d last=%0d",
               first_rise, last_rise, D, 15 * D);
    end
    n_cmp++;
    if (dnc_bad != 0) begin n_fail++; $display("FAIL cmd_dnc got bad_cycles=%0d want=0", dnc_bad); end
  endtask

  // Reference model: grant order from the arbitration rules; grant spacing
  // and nCS-high time from the frame length and burst setting.
  task automatic run_traffic(input int cn, input int dn, input logic [7:0] c0, input logic [7:0] d0);
    bit got, isd, w, rc, rd, prev_w, first, ok;
    int t, nh, run, prev_t, exp_s, gap_exp, gap_got;
    logic [7:0] cb, db;
    cb = c0; db = d0;
    cmd_byte = cb; data_byte = db;
    cmd_req = (cn > 0); data_req = (dn > 0);
    run = 0; prev_t = 0; prev_w = 1'b0; first = 1'b1; gap_exp = 0; gap_got = 0;
    while (cn + dn > 0) begin
      rc = (cn > 0); rd = (dn > 0);
      w = rd && (!rc || run == MAXR);
      wait_grant(got, isd, t, nh);
      n_cmp++;
      if (!got) begin
        n_fail++;
        $display("FAIL grant_timeout got=none want=%s", w ? "D" : "C");
        break;
      end
      n_cmp++;
      if (isd !== w) begin
        n_fail++;
        $display("FAIL grant_order got=%s want=%s run=%0d", isd ? "D" : "C", w ? "D" : "C", run);
      end
      exp_q.push_back({w, w ? db : cb});
      if (!first) begin
        exp_s = (BURST && w == prev_w) ? 17 * D : 18 * D + 1;
        gap_exp += exp_s - 17 * D;
        gap_got += nh;
        n_cmp++;
        if (t - prev_t != exp_s) begin
          n_fail++;
          $display("FAIL grant_spacing got=%0d want=%0d", t - prev_t, exp_s);
        end
      end
      if (w) run = 0;
      else run = rd ? run + 1 : 0;
      if (w) begin
        dn--;
        if (dn == 0) data_req = 1'b0;
        else begin db = 8'($urandom_range(0, 255)); data_byte = db; end
      end else begin
        cn--;
        if (cn == 0) cmd_req = 1'b0;
        else begin cb = 8'($urandom_range(0, 255)); cmd_byte = cb; end
      end
      prev_t = t; prev_w = w; first = 1'b0;
    end
    cmd_req = 1'b0; data_req = 1'b0;
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL idle_timeout got busy=%b ncs=%b want busy=0 ncs=1", busy, ncs); end
    n_cmp++;
    if (gap_got != gap_exp) begin n_fail++; $display("FAIL ncs_high_between got=%0d want=%0d", gap_got, gap_exp); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bytes_missing got=%0d left want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_data_only();
    run_traffic(0, 1, 8'h00, 8'h3C);
    // a clean run counter gives C,C,D with both requesting
    run_traffic(2, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_arbitration();
    run_traffic(5, 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    for (int k = 0; k < 3; k++)
      run_traffic($urandom_range(1, 5), $urandom_range(1, 4),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_back_to_back();
    run_traffic(0, 3, 8'h00, 8'($urandom_range(0, 255)));
    run_traffic(3, 0, 8'($urandom_range(0, 255)), 8'h00);
  endtask

  task automatic test_reset_mid_byte();
    bit got, isd, ok;
    int t, nh;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    cmd_byte = b; cmd_req = 1'b1;
    exp_q.push_back({1'b0, b});
    wait_grant(got, isd, t, nh);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL rst_first_grant got=none want=C"); end
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ncs, sclk, busy, sdin, dnc, cmd_ack, data_ack} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL mid_byte_reset got ncs,sclk,busy,sdin,dnc,cack,dack=%b want=1000000",
               {ncs, sclk, busy, sdin, dnc, cmd_ack, data_ack});
    end
    exp_q.delete();
    exp_q.push_back({1'b0, b});
    rst = 1'b0;
    wait_grant(got, isd, t, nh);
    n_cmp++;
    if (!got || isd) begin n_fail++; $display("FAIL rst_regrant got got/is_data=%b%b want=10", got, isd); end
    cmd_req = 1'b0;
    wait_idle(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_regrant_done got idle=%b left=%0d want idle=1 left=0", ok, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_cmd(8'hA5);
    test_single_cmd(8'($urandom_range(0, 255)));
    test_data_only();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
